// File: rtl/slc_state_readback.sv
// slc_state_readback: captures one super logic cell's AQZ/BQZ/CQZ/CO on CAP
// and streams the snapshot LSB first over an SDO/SVAL/SRDY handshake.
// Optional feature macro: SLC_READBACK_PARITY_EN appends an even-parity bit after CO.
module slc_state_readback #(
  parameter int NUM_LC = 8
) (
  input  logic              QCK,
  input  logic              QRT,
  input  logic              CAP,
  input  logic [NUM_LC-1:0] AQZ,
  input  logic [NUM_LC-1:0] BQZ,
  input  logic [NUM_LC-1:0] CQZ,
  input  logic              CO,
  output logic              SDO,
  output logic              SVAL,
  input  logic              SRDY,
  output logic              SFRM,
  output logic              BUSY,
  output logic              OVF,
  input  logic              OVF_CLR
);

`ifdef SLC_READBACK_PARITY_EN
  localparam int FRAME_BITS = 3*NUM_LC + 2;
`else
  localparam int FRAME_BITS = 3*NUM_LC + 1;
`endif
  localparam int CW = $clog2(FRAME_BITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d, snap;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sfrm_q, sfrm_d;
  logic                  ovf_q, ovf_d;
  logic                  drop;

  // Snapshot word in transmit order, AQZ[0] in bit 0.
  always_comb begin
`ifdef SLC_READBACK_PARITY_EN
    snap = {^{CO, CQZ, BQZ, AQZ}, CO, CQZ, BQZ, AQZ};
`else
    snap = {CO, CQZ, BQZ, AQZ};
`endif
  end

  // Next-state logic: capture, shift on handshake, back-to-back reload, drop detection.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sfrm_d  = sfrm_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (CAP) begin
          sr_d    = snap;
          cnt_d   = CW'(FRAME_BITS - 1);
          sfrm_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (SRDY) begin
          if (cnt_q == '0) begin
            if (CAP) begin
              sr_d   = snap;
              cnt_d  = CW'(FRAME_BITS - 1);
              sfrm_d = 1'b1;
            end else begin
              sr_d    = sr_q >> 1;
              sfrm_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            sr_d   = sr_q >> 1;
            cnt_d  = cnt_q - CW'(1);
            sfrm_d = 1'b0;
          end
        end
        // Any CAP in SHIFT except one coinciding with the final transfer is lost.
        if (CAP && !(SRDY && (cnt_q == '0))) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set has priority over clear.
    ovf_d = drop | (ovf_q & ~OVF_CLR);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sfrm_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sfrm_q  <= sfrm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode directly from flops so reset clears them immediately.
  assign SVAL = (state_q == SHIFT);
  assign BUSY = (state_q == SHIFT);
  assign SDO  = (state_q == SHIFT) & sr_q[0];
  assign SFRM = (state_q == SHIFT) & sfrm_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_slc_state_readback.sv
// tb_slc_state_readback: table-driven frame checks plus directed sequences
// for reset, overflow and back-to-back capture.
module tb_slc_state_readback;

`ifdef SLC_READBACK_PARITY_EN
  localparam int FB = 26;
`else
  localparam int FB = 25;
`endif

  logic       QCK = 1'b0;
  logic       QRT = 1'b0;
  logic       CAP = 1'b0;
  logic [7:0] AQZ = '0, BQZ = '0, CQZ = '0;
  logic       CO = 1'b0;
  logic       SDO, SVAL, SFRM, BUSY, OVF;
  logic       SRDY = 1'b1;
  logic       OVF_CLR = 1'b0;

  int errors = 0;
  int checks = 0;

  slc_state_readback #(.NUM_LC(8)) dut (
    .QCK(QCK), .QRT(QRT), .CAP(CAP), .AQZ(AQZ), .BQZ(BQZ), .CQZ(CQZ), .CO(CO),
    .SDO(SDO), .SVAL(SVAL), .SRDY(SRDY), .SFRM(SFRM), .BUSY(BUSY),
    .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  always #5 QCK = ~QCK;

  typedef struct {
    logic [7:0]  a, b, c;
    logic        co;
    logic [24:0] exp25;
    logic        par;
    logic        bp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FB-1:0] mk_exp(input logic [24:0] e, input logic p);
`ifdef SLC_READBACK_PARITY_EN
    return {p, e};
`else
    return (p == 1'b0 || p == 1'b1) ? e : e;
`endif
  endfunction

  // Runs one frame from the current negedge. cap_at/abort_at < 0 disables them.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic co, input logic [FB-1:0] exp, input logic bp,
                           input int cap_at, input logic cap_clr, input logic last_cap,
                           input logic skip_cap, input int abort_at);
    int  i;
    int  cyc;
    logic srdy;
    logic cap_done;
    if (!skip_cap) begin
      AQZ = a; BQZ = b; CQZ = c; CO = co; CAP = 1'b1;
      @(negedge QCK);
      CAP = 1'b0;
    end
    i = 0; cyc = 0; cap_done = 1'b0;
    while (i < FB && cyc < 400) begin
      if (i == abort_at) begin
        #2 QRT = 1'b0;
        #1;
        check("rst_sval", SVAL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_sfrm", SFRM, 0);
        check("rst_sdo", SDO, 0);
        @(negedge QCK);
        QRT = 1'b1;
        return;
      end
      check("sval", SVAL, 1);
      check("sdo", SDO, exp[i]);
      check("sfrm", SFRM, (i == 0) ? 1 : 0);
      srdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      SRDY = srdy;
      if (i == cap_at && !cap_done) begin
        CAP = 1'b1; OVF_CLR = cap_clr; cap_done = 1'b1;
      end
      if (last_cap && i == FB - 1 && srdy) begin
        CAP = 1'b1; AQZ = 8'h01;
      end
      @(posedge QCK);
      if (srdy) i++;
      cyc++;
      @(negedge QCK);
      CAP = 1'b0; OVF_CLR = 1'b0;
    end
    check("frame_timeout", (cyc < 400) ? 1 : 0, 1);
    SRDY = 1'b1;
    if (last_cap) begin
      check("b2b_sval", SVAL, 1);
      check("b2b_sfrm", SFRM, 1);
      check("b2b_sdo", SDO, 1);
    end else begin
      check("end_sval", SVAL, 0);
      check("end_busy", BUSY, 0);
      check("end_sfrm", SFRM, 0);
    end
  endtask

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'h3C, c: 8'hF0, co: 1'b1, exp25: 25'h1F03CA5, par: 1'b1, bp: 1'b0};
    vecs[1] = '{a: 8'hA5, b: 8'h3C, c: 8'hF0, co: 1'b1, exp25: 25'h1F03CA5, par: 1'b1, bp: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h00, c: 8'h00, co: 1'b0, exp25: 25'h0000000, par: 1'b0, bp: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, c: 8'hFF, co: 1'b1, exp25: 25'h1FFFFFF, par: 1'b1, bp: 1'b1};
    vecs[4] = '{a: 8'h01, b: 8'h80, c: 8'h00, co: 1'b0, exp25: 25'h0008001, par: 1'b0, bp: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'h00, c: 8'h00, co: 1'b0, exp25: 25'h00000FF, par: 1'b0, bp: 1'b1};

    // Reset values, applied without any clock edge yet.
    #1;
    check("reset_sdo", SDO, 0);
    check("reset_sval", SVAL, 0);
    check("reset_sfrm", SFRM, 0);
    check("reset_busy", BUSY, 0);
    check("reset_ovf", OVF, 0);
    @(negedge QCK);
    QRT = 1'b1;
    @(negedge QCK);
    check("idle_sval", SVAL, 0);

    // Table-driven frames, some under 1,0,0,1 backpressure.
    for (int k = 0; k < 6; k++) begin
      run_frame(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].co,
                mk_exp(vecs[k].exp25, vecs[k].par), vecs[k].bp, -1, 1'b0, 1'b0, 1'b0, -1);
      @(negedge QCK);
    end
    check("no_ovf_yet", OVF, 0);

    // Reset mid-frame after 5 transfers, then a fresh frame.
    run_frame(8'hA5, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03CA5, 1'b1), 1'b0, -1, 1'b0, 1'b0, 1'b0, 5);
    @(negedge QCK);
    check("post_rst_idle", SVAL, 0);
    run_frame(8'hA5, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03CA5, 1'b1), 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);

    // Overflow: dropped CAP at transfer 10 leaves frame intact.
    run_frame(8'hA5, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03CA5, 1'b1), 1'b0, 10, 1'b0, 1'b0, 1'b0, -1);
    check("ovf_set", OVF, 1);
    @(negedge QCK);
    check("ovf_held", OVF, 1);
    // Set and clear together: set wins.
    run_frame(8'hA5, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03CA5, 1'b1), 1'b1, 7, 1'b1, 1'b0, 1'b0, -1);
    check("ovf_set_wins", OVF, 1);
    OVF_CLR = 1'b1;
    @(negedge QCK);
    OVF_CLR = 1'b0;
    check("ovf_cleared", OVF, 0);

    // Back-to-back: CAP on the last transfer edge with AQZ=01, no SVAL gap.
    run_frame(8'hA5, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03CA5, 1'b1), 1'b0, -1, 1'b0, 1'b1, 1'b0, -1);
    run_frame(8'h01, 8'h3C, 8'hF0, 1'b1, mk_exp(25'h1F03C01, 1'b0), 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);
    check("b2b_no_ovf", OVF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slc_state_readback.md
Name: slc_state_readback

Overview:
- Readback end of the super-logic-cell register interface: snapshots the AQZ/BQZ/CQZ flip-flop outputs and CO of one super logic cell on request.
- Streams the snapshot out as a serial frame over a valid/ready handshake.
- Sits beside each SLC in the AP3 debug/verification fabric. Its output feeds the readback chain collector.

Parameters:
- NUM_LC, 8, logic cells per super logic cell; sets the AQZ/BQZ/CQZ input widths.
- FRAME_BITS, 3*NUM_LC+1 (+1 with parity feature), frame length; derived, not overridable.

Ports:
- QCK  input  1  clock; all state updates on rising edge.
- QRT  input  1  reset, asynchronous, active-low.
- CAP  input  1  capture request, sampled each rising edge.
- AQZ  input  NUM_LC  AQZ outputs of the cells.
- BQZ  input  NUM_LC  BQZ outputs of the cells.
- CQZ  input  NUM_LC  CQZ outputs of the cells.
- CO  input  1  carry-out of the last cell.
- SDO  output  1  serial data bit.
- SVAL  output  1  SDO valid.
- SRDY  input  1  consumer ready.
- SFRM  output  1  high while SDO carries bit 0 of a frame.
- BUSY  output  1  frame in progress.
- OVF  output  1  sticky: a capture request was dropped.
- OVF_CLR  input  1  clears OVF.

Behaviour:
- Reset (QRT=0, async): state IDLE; shift register and bit counter cleared; SDO=0, SVAL=0, SFRM=0, BUSY=0, OVF=0. Outputs drop immediately, not at the next edge.
- Frame order, LSB first: AQZ[0..NUM_LC-1], BQZ[0..NUM_LC-1], CQZ[0..NUM_LC-1], CO, then parity if enabled.
- States are IDLE and SHIFT.
- IDLE:
  - SVAL=0, BUSY=0.
  - CAP=1 at an edge loads the shift register from the inputs at that edge, sets the counter to FRAME_BITS-1 and enters SHIFT.
  - SVAL=1 and SFRM=1 from the cycle after the CAP edge (1-cycle latency).
- SHIFT:
  - SVAL=1, BUSY=1, SDO = shift register bit 0.
  - A transfer occurs at an edge with SVAL&SRDY=1. On transfer: shift right, decrement counter, SFRM=0.
  - With SRDY=0, SDO/SFRM/counter hold indefinitely. SDO must not change while SVAL=1 and SRDY=0.
  - Last bit (counter=0) transferred, CAP=0: go to IDLE, SVAL=0 next cycle.
  - Last bit transferred, CAP=1: reload a new snapshot in the same edge and stay in SHIFT with SFRM=1. This gives back-to-back frames with no SVAL gap.
  - CAP=1 at any other SHIFT edge: request dropped, OVF set, frame unaffected.
- OVF:
  - Set by a dropped CAP; cleared by OVF_CLR.
  - Set and clear in the same cycle: set wins.
- Counter width is clog2(FRAME_BITS). The counter never wraps; it is reloaded only on capture.
- Inputs are treated as synchronous to QCK; no synchronizers inside.

Optional Feature:
- Macro SLC_READBACK_PARITY_EN.
- Defined: one extra bit is appended after CO, the even-parity bit (XOR of all snapshot bits), so FRAME_BITS = 3*NUM_LC+2. The parity is computed at capture from the loaded data.
- Undefined: no parity bit; FRAME_BITS = 3*NUM_LC+1, and no parity logic is present.

Test Plan:
- Reset mid-frame: assert QRT=0 after 5 transfers -> SVAL/BUSY/SFRM go 0 without a clock edge. After release the block sits in IDLE; the next CAP starts a fresh frame with SFRM=1.
- Basic frame, NUM_LC=8, AQZ=8'hA5, BQZ=8'h3C, CQZ=8'hF0, CO=1, CAP pulse, SRDY=1:
  - SVAL rises 1 cycle after CAP; SFRM high for the first bit only.
  - 25 bits: 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,0,0,0,1,1,1,1, 1.
  - SVAL=0 after the 25th transfer.
- Backpressure: same data, SRDY toggles 1,0,0,1 repeating -> identical bit sequence; SDO stable during every SRDY=0 cycle; total 25 transfers.
- Overflow: CAP re-asserted at transfer 10 -> frame unchanged, OVF=1 and held. OVF_CLR and a new dropped CAP in the same cycle -> OVF stays 1. OVF_CLR alone -> OVF=0.
- Back-to-back: CAP=1 at the edge of the last transfer with AQZ changed to 8'h01 -> the next cycle has SVAL=1, SFRM=1, SDO=1, with no idle gap.
- Parity (SLC_READBACK_PARITY_EN defined), basic-frame data: 13 ones, so bit 26 = 1 and FRAME_BITS=26. With all inputs 0 -> 26 zero bits.
